// File: rtl/i2c_bus_monitor.sv
// i2c_bus_monitor: passive I2C decoder that reports START/STOP and each received byte with its ACK.
module i2c_bus_monitor #(
    parameter int FILTER_LEN = 3,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 sda_in,
    input  logic                 scl_in,
    input  logic [6:0]           match_addr,
    output logic                 start_det,
    output logic                 stop_det,
    output logic                 byte_valid,
    output logic [7:0]           byte_data,
    output logic                 byte_ack,
    output logic                 byte_is_addr,
    output logic                 addr_match,
    output logic                 frame_err,
    output logic                 bus_busy,
    output logic [CNT_WIDTH-1:0] byte_cnt
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    typedef enum logic [1:0] {IDLE, ADDR, DATA, WAIT} state_t;
    state_t             state;
    logic [1:0]         s1, s2, filt, prev;  // bit 0 = SDA, bit 1 = SCL
    logic [1:0][FW-1:0] fcnt;
    logic [3:0]         bit_cnt;
    logic [7:0]         shreg;
    logic               start_c, stop_c, scl_rise, in_byte;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1   <= '1;
            s2   <= '1;
            filt <= '1;
            prev <= '1;
            fcnt <= '0;
        end else begin
            s1   <= {scl_in, sda_in};
            s2   <= s1;
            prev <= filt;
            for (int i = 0; i < 2; i++)
                if (s2[i] == filt[i])
                    fcnt[i] <= '0;
                else if (fcnt[i] == FW'(FILTER_LEN - 1)) begin
                    filt[i] <= s2[i];
                    fcnt[i] <= '0;
                end else
                    fcnt[i] <= fcnt[i] + FW'(1);
        end
    end

    // SCL held high across both cycles also excludes a simultaneous SCL edge
    assign start_c  = filt[1] && prev[1] && prev[0] && !filt[0];
    assign stop_c   = filt[1] && prev[1] && !prev[0] && filt[0];
    assign scl_rise = filt[1] && !prev[1];
    assign in_byte  = state == ADDR || state == DATA;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            bit_cnt      <= '0;
            shreg        <= '0;
            start_det    <= 1'b0;
            stop_det     <= 1'b0;
            byte_valid   <= 1'b0;
            byte_data    <= '0;
            byte_ack     <= 1'b0;
            byte_is_addr <= 1'b0;
            addr_match   <= 1'b0;
            frame_err    <= 1'b0;
            bus_busy     <= 1'b0;
            byte_cnt     <= '0;
        end else begin
            start_det  <= 1'b0;
            stop_det   <= 1'b0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            if (!enable) begin
                state    <= IDLE;
                bit_cnt  <= '0;
                bus_busy <= 1'b0;
            end else if (start_c) begin
                start_det <= 1'b1;
                frame_err <= in_byte && bit_cnt != 4'd0;
                state     <= ADDR;
                bit_cnt   <= '0;
                byte_cnt  <= '0;
                bus_busy  <= 1'b1;
            end else if (stop_c) begin
                stop_det  <= 1'b1;
                frame_err <= in_byte && bit_cnt != 4'd0;
                state     <= IDLE;
                bit_cnt   <= '0;
                bus_busy  <= 1'b0;
            end else if (scl_rise && in_byte) begin
                if (bit_cnt == 4'd8) begin
                    byte_valid   <= 1'b1;
                    byte_data    <= shreg;
                    byte_ack     <= !filt[0];
                    byte_is_addr <= state == ADDR;
                    addr_match   <= state == ADDR && shreg[7:1] == match_addr;
                    byte_cnt     <= byte_cnt + CNT_WIDTH'(byte_cnt != '1);
                    bit_cnt      <= '0;
                    state        <= filt[0] ? WAIT : DATA;
                end else begin
                    shreg   <= {shreg[6:0], filt[0]};
                    bit_cnt <= bit_cnt + 4'd1;
                end
            end
        end
    end
endmodule
